mux_stream_arb: RTL and testbench

//  Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes
//  and a one-entry registered output stage. Selects one input per cycle, by

---
 rtl/mux_stream_arb_if.sv | 30 +++
 rtl/mux_stream_arb.sv | 95 +++++++++
 tb/tb_mux_stream_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_stream_arb_if.sv
// Stream mux bundle: N producer channels in, one registered stream out, plus force controls.
// No storage; carries the signals only.
// Flow control is plain valid/ready on both sides.
interface mux_stream_arb_if #(
    parameter int N  = 4,
    parameter int W  = 2,
    parameter int SW = (N <= 2) ? 1 : $clog2(N)
);
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           force_en;
    logic [SW-1:0]  force_sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_ready;

    // Environment side: producers, force control and the consumer's ready.
    modport master (
        output in_valid, in_data, force_en, force_sel, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    // Arbiter side.
    modport slave (
        input  in_valid, in_data, force_en, force_sel, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/mux_stream_arb.sv
// N-channel stream mux: round-robin / fixed-priority / forced grant into a one-entry output register.
// Latency 1 cycle from input handshake to out_data; full throughput of 1 word/cycle.
// Backpressure: out_ready=0 with a held word freezes the register, pointer and drops all in_ready.
module mux_stream_arb #(
    parameter int N        = 4,
    parameter int W        = 2,
    parameter int ARB_MODE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_stream_arb_if.slave bus
);
    localparam int SW = (N <= 2) ? 1 : $clog2(N);

    logic [SW-1:0]  ptr;
    logic [N-1:0]   elig;
    logic [2*N-1:0] elig_dbl;
    logic [SW:0]    rot_amt;
    logic [N-1:0]   elig_rot;
    logic           grant_vld;
    logic [SW-1:0]  grant;
    logic [W-1:0]   grant_dat;
    logic           load_en;
    logic           hs;

    // Register can take a word when empty or being drained this cycle.
    assign load_en = !bus.out_valid || bus.out_ready;

    // Eligible set; an out-of-range force_sel matches no channel, so nothing is eligible.
    always_comb begin
        elig = '0;
        if (bus.force_en) begin
            for (int k = 0; k < N; k++) begin
                if (bus.force_sel == SW'(k)) elig[k] = bus.in_valid[k];
            end
        end else begin
            elig = bus.in_valid;
        end
    end

    // Rotate the eligible set so bit 0 is the channel just after the pointer.
    assign rot_amt  = {1'b0, ptr} + (SW+1)'(1);
    assign elig_dbl = {elig, elig} >> rot_amt;
    assign elig_rot = elig_dbl[N-1:0];

    // Grant: lowest eligible index, or first eligible after the pointer; descending loop lets the winner assign last.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (ARB_MODE == 0) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (elig[k]) begin
                    grant_vld = 1'b1;
                    grant     = SW'(k);
                end
            end
        end else begin
            for (int j = N - 1; j >= 0; j--) begin
                if (elig_rot[j]) begin
                    grant_vld = 1'b1;
                    grant     = SW'((int'(ptr) + 1 + j) % N);
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        grant_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (grant == SW'(k)) grant_dat = bus.in_data[k*W +: W];
        end
    end

    // One-hot ready to the granted channel only, held low through reset.
    assign bus.in_ready = (rst_n && load_en && grant_vld) ? (N'(1) << grant) : '0;
    assign hs           = |(bus.in_valid & bus.in_ready);

    // Output register and round-robin pointer; pointer moves only on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= SW'(N - 1);
        end else if (hs) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= grant_dat;
            bus.out_ch    <= grant;
            ptr           <= grant;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_stream_arb.sv
// Bench for mux_stream_arb: three instances (RR N=4, fixed-priority N=4, RR N=5) share one stimulus.
// A behavioural model predicts in_ready and the output register every cycle.
// Directed phases pin the model with literal expectations, then random traffic runs.
module tb_mux_stream_arb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] vld;
    logic [9:0] dat;
    logic       fen;
    logic [2:0] fsel;
    logic       ordy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_stream_arb_if #(.N(4), .W(2)) bus_rr ();
    mux_stream_arb_if #(.N(4), .W(2)) bus_fp ();
    mux_stream_arb_if #(.N(5), .W(2)) bus_n5 ();

    assign bus_rr.in_valid  = vld[3:0];
    assign bus_rr.in_data   = dat[7:0];
    assign bus_rr.force_en  = fen;
    assign bus_rr.force_sel = fsel[1:0];
    assign bus_rr.out_ready = ordy;

    assign bus_fp.in_valid  = vld[3:0];
    assign bus_fp.in_data   = dat[7:0];
    assign bus_fp.force_en  = fen;
    assign bus_fp.force_sel = fsel[1:0];
    assign bus_fp.out_ready = ordy;

    assign bus_n5.in_valid  = vld;
    assign bus_n5.in_data   = dat;
    assign bus_n5.force_en  = fen;
    assign bus_n5.force_sel = fsel;
    assign bus_n5.out_ready = ordy;

    mux_stream_arb #(.N(4), .W(2), .ARB_MODE(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));
    mux_stream_arb #(.N(4), .W(2), .ARB_MODE(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(bus_fp.slave));
    mux_stream_arb #(.N(5), .W(2), .ARB_MODE(1)) u_n5 (.clk(clk), .rst_n(rst_n), .bus(bus_n5.slave));

    logic [4:0] a_rdy [3];
    logic       a_ov  [3];
    logic [1:0] a_od  [3];
    logic [2:0] a_oc  [3];

    assign a_rdy[0] = 5'(bus_rr.in_ready);
    assign a_rdy[1] = 5'(bus_fp.in_ready);
    assign a_rdy[2] = bus_n5.in_ready;
    assign a_ov[0]  = bus_rr.out_valid;
    assign a_ov[1]  = bus_fp.out_valid;
    assign a_ov[2]  = bus_n5.out_valid;
    assign a_od[0]  = bus_rr.out_data;
    assign a_od[1]  = bus_fp.out_data;
    assign a_od[2]  = bus_n5.out_data;
    assign a_oc[0]  = 3'(bus_rr.out_ch);
    assign a_oc[1]  = 3'(bus_fp.out_ch);
    assign a_oc[2]  = bus_n5.out_ch;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d got %0h expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    function automatic int nch(input int i);
        return (i == 2) ? 5 : 4;
    endfunction

    function automatic int mode(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    // Which channel the rules pick this cycle; -1 when none.
    function automatic int pick(input int n, input int md, input logic [4:0] v,
                                input logic fe, input int fs, input int ptr);
        if (fe) begin
            if (fs < n) begin
                if (v[fs]) return fs;
            end
            return -1;
        end
        for (int s = 1; s <= n; s++) begin
            int k;
            k = (md == 0) ? s - 1 : (ptr + s) % n;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Model state per instance: the held word and the last channel served.
    logic       m_v [3];
    logic [1:0] m_d [3];
    int         m_c [3];
    int         m_p [3];

    // Compare DUT against the model at every falling edge, then advance the model.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int n, fs, g;
            logic ld;
            logic [4:0] er;
            n = nch(i);
            if (!rst_n) begin
                chk("rst_in_ready", i, 32'(a_rdy[i]), 32'd0);
                chk("rst_out_valid", i, 32'(a_ov[i]), 32'd0);
                chk("rst_out_data", i, 32'(a_od[i]), 32'd0);
                chk("rst_out_ch", i, 32'(a_oc[i]), 32'd0);
                m_v[i] = 1'b0;
                m_d[i] = 2'd0;
                m_c[i] = 0;
                m_p[i] = n - 1;
            end else begin
                fs = (i == 2) ? int'(fsel) : int'(fsel[1:0]);
                ld = !m_v[i] || ordy;
                g  = pick(n, mode(i), vld, fen, fs, m_p[i]);
                er = (ld && g >= 0) ? 5'(1 << g) : 5'd0;
                chk("in_ready", i, 32'(a_rdy[i]), 32'(er));
                chk("out_valid", i, 32'(a_ov[i]), 32'(m_v[i]));
                chk("out_data", i, 32'(a_od[i]), 32'(m_d[i]));
                chk("out_ch", i, 32'(a_oc[i]), 32'(m_c[i]));
                if (ld && g >= 0) begin
                    m_v[i] = 1'b1;
                    m_d[i] = dat[g*2 +: 2];
                    m_c[i] = g;
                    m_p[i] = g;
                end else if (m_v[i] && ordy) begin
                    m_v[i] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = '0;
        dat   = '0;
        fen   = 1'b0;
        fsel  = '0;
        ordy  = 1'b0;
        tick();
        tick();
        chk("lit_reset_ov", 0, 32'(bus_rr.out_valid), 32'd0);
        chk("lit_reset_rdy", 0, 32'(bus_rr.in_ready), 32'd0);

        // Round-robin with everything valid; channel k carries data k.
        rst_n = 1'b1;
        dat   = 10'b00_11_10_01_00;
        vld   = 5'b11111;
        ordy  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_rr_ch", 0, 32'(bus_rr.out_ch), 32'(i % 4));
            chk("t2_rr_ov", 0, 32'(bus_rr.out_valid), 32'd1);
            chk("t2_fp_ch", 1, 32'(bus_fp.out_ch), 32'd0);
        end

        // Fixed priority picks the lowest valid channel.
        vld = 5'b01010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_fp_ch1", 1, 32'(bus_fp.out_ch), 32'd1);
        end
        vld = 5'b01000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_fp_ch3", 1, 32'(bus_fp.out_ch), 32'd3);
        end

        // Back-pressure on a word from channel 2.
        vld = 5'b00100;
        tick();
        chk("t4_load_ch", 0, 32'(bus_rr.out_ch), 32'd2);
        ordy      = 1'b0;
        vld       = 5'b11111;
        dat[5:4]  = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_data", 0, 32'(bus_rr.out_data), 32'h2);
            chk("t4_hold_ch", 0, 32'(bus_rr.out_ch), 32'd2);
            chk("t4_hold_rdy", 0, 32'(bus_rr.in_ready), 32'd0);
        end
        ordy = 1'b1;
        #1;
        chk("t4_next_grant", 0, 32'(bus_rr.in_ready), 32'h8);
        dat[5:4] = 2'b10;

        // Forced channel 2, then an out-of-range force on the 5-channel instance.
        fen  = 1'b1;
        fsel = 3'b010;
        for (int i = 0; i < 20; i++) begin
            tick();
            ordy = 1'($urandom_range(0, 1));
            #1;
            chk("t5_force_rr", 0, 32'(bus_rr.in_ready & 4'b1011), 32'd0);
            chk("t5_force_n5", 2, 32'(bus_n5.in_ready & 5'b11011), 32'd0);
        end
        fsel = 3'b101;
        ordy = 1'b1;
        tick();
        tick();
        chk("t5_oor_drain", 2, 32'(bus_n5.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_oor_rdy", 2, 32'(bus_n5.in_ready), 32'd0);
        end

        // Sparse round-robin: after channel 0, channels 3 then 0.
        fen = 1'b0;
        vld = 5'b00001;
        tick();
        chk("t6_ch0", 0, 32'(bus_rr.out_ch), 32'd0);
        vld = 5'b01001;
        tick();
        chk("t6_ch3", 0, 32'(bus_rr.out_ch), 32'd3);
        tick();
        chk("t6_ch0b", 0, 32'(bus_rr.out_ch), 32'd0);

        // Asynchronous reset while a word is held.
        vld = 5'b11111;
        tick();
        tick();
        chk("t1_pre_ch", 0, 32'(bus_rr.out_ch), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t1_ov", 0, 32'(bus_rr.out_valid), 32'd0);
        chk("t1_od", 0, 32'(bus_rr.out_data), 32'd0);
        chk("t1_oc", 0, 32'(bus_rr.out_ch), 32'd0);
        chk("t1_rdy", 0, 32'(bus_rr.in_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_first_ch", 0, 32'(bus_rr.out_ch), 32'd0);
        chk("t1_first_ov", 0, 32'(bus_rr.out_valid), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            vld  = 5'($urandom);
            dat  = 10'($urandom);
            ordy = ($urandom_range(0, 9) < 7);
            fen  = ($urandom_range(0, 9) == 0);
            fsel = 3'($urandom);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
